muldiv_unit: RTL

Parametrised multicycle multiply/divide unit for the CPU datapath, generalising the existing 32-bit divider. Supports signed and unsigned multiply and divide, selected by an op code, and writes results to HI/LO registers. A start/busy/done handshake lets the control FSM stall while it runs. Division uses restoring shift-subtract and multiplication uses shift-add, each one bit per cycle.

---
 rtl/muldiv_unit.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Multicycle signed/unsigned multiply/divide (shift-add / restoring shift-subtract, one bit per cycle) into HI/LO.
// Latency N_BITS+1 cycles from the start edge (1 cycle on divide-by-zero); start is ignored while busy.
module muldiv_unit #(
    parameter int N_BITS = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_BITS-1:0] srcA,
    input  logic [N_BITS-1:0] srcB,
    input  logic              start,
    input  logic [1:0]        op,
    output logic              busy,
    output logic              done,
    output logic              divZero,
    output logic [N_BITS-1:0] hi,
    output logic [N_BITS-1:0] lo
);

    localparam int CW = $clog2(N_BITS + 1);
    localparam logic [CW-1:0] C_ITER = CW'(N_BITS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_is_div;
    logic                  r_neg_res;
    logic                  r_neg_rem;
    logic                  r_dz;
    logic [N_BITS-1:0]     r_mag_b;
    logic [N_BITS-1:0]     r_mag_a;
    logic [CW-1:0]         r_cnt;
    logic [2*N_BITS-1:0]   r_acc;
    logic [N_BITS:0]       r_rem;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_div_zero;
    logic [N_BITS-1:0]     r_hi;
    logic [N_BITS-1:0]     r_lo;

    logic                  w_signed;
    logic                  w_is_div;
    logic                  w_neg_a;
    logic                  w_neg_b;
    logic [N_BITS-1:0]     w_abs_a;
    logic [N_BITS-1:0]     w_abs_b;
    logic                  w_b_zero;
    logic [N_BITS-1:0]     w_addend;
    logic [N_BITS:0]       w_mul_sum;
    logic [2*N_BITS-1:0]   w_mul_nxt;
    logic [N_BITS+1:0]     w_div_shift;
    logic [N_BITS+1:0]     w_div_diff;
    logic                  w_div_ok;
    logic [N_BITS:0]       w_rem_nxt;
    logic [N_BITS-1:0]     w_quo_nxt;
    logic [2*N_BITS-1:0]   w_prod;
    logic [N_BITS-1:0]     w_quo;
    logic [N_BITS-1:0]     w_rem;

    // Operand conditioning at accept time: signed ops work on magnitudes, signs fixed up in FIX.
    assign w_signed = ~op[0];
    assign w_is_div = op[1];
    assign w_neg_a  = w_signed & srcA[N_BITS-1];
    assign w_neg_b  = w_signed & srcB[N_BITS-1];
    assign w_abs_a  = w_neg_a ? -srcA : srcA;
    assign w_abs_b  = w_neg_b ? -srcB : srcB;
    assign w_b_zero = (srcB == '0);

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    assign w_addend  = r_acc[0] ? r_mag_a : '0;
    assign w_mul_sum = {1'b0, r_acc[2*N_BITS-1:N_BITS]} + {1'b0, w_addend};
    assign w_mul_nxt = {w_mul_sum, r_acc[N_BITS-1:1]};

    // Divide: acc[N-1:0] shifts dividend bits out and quotient bits in; borrow decides restore.
    assign w_div_shift = {r_rem, r_acc[N_BITS-1]};
    assign w_div_diff  = w_div_shift - {2'b00, r_mag_b};
    assign w_div_ok    = ~w_div_diff[N_BITS+1];
    assign w_rem_nxt   = w_div_ok ? w_div_diff[N_BITS:0] : w_div_shift[N_BITS:0];
    assign w_quo_nxt   = {r_acc[N_BITS-2:0], w_div_ok};

    assign w_prod = r_neg_res ? -r_acc : r_acc;
    assign w_quo  = r_neg_res ? -r_acc[N_BITS-1:0] : r_acc[N_BITS-1:0];
    assign w_rem  = r_neg_rem ? -r_rem[N_BITS-1:0] : r_rem[N_BITS-1:0];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (w_is_div && w_b_zero) ? S_FIX : S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == CW'(1)) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_is_div   <= 1'b0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_dz       <= 1'b0;
            r_mag_a    <= '0;
            r_mag_b    <= '0;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_rem      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= (r_state == S_FIX);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_is_div   <= w_is_div;
                        r_neg_res  <= w_neg_a ^ w_neg_b;
                        r_neg_rem  <= w_neg_a;
                        r_dz       <= w_is_div & w_b_zero;
                        r_mag_a    <= w_abs_a;
                        r_mag_b    <= w_abs_b;
                        r_cnt      <= C_ITER;
                        r_rem      <= '0;
                        r_acc      <= w_is_div ? {{N_BITS{1'b0}}, w_abs_a}
                                               : {{N_BITS{1'b0}}, w_abs_b};
                        r_div_zero <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_is_div) begin
                        r_rem              <= w_rem_nxt;
                        r_acc[N_BITS-1:0]  <= w_quo_nxt;
                    end else begin
                        r_acc <= w_mul_nxt;
                    end
                end
                S_FIX: begin
                    if (r_dz) begin
                        r_div_zero <= 1'b1;
                    end else if (r_is_div) begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end else begin
                        r_hi <= w_prod[2*N_BITS-1:N_BITS];
                        r_lo <= w_prod[N_BITS-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign divZero = r_div_zero;
    assign hi      = r_hi;
    assign lo      = r_lo;

endmodule
